reg_list_sequencer: RTL and testbench

Register-list sequencer for multi-register transfers (LDM/STM-style). It captures an NREG-bit register list and walks the set bits one per enabled cycle in a programmable order. For each step it presents the register index and a one-hot register-file write/read enable. It sits between the instruction decode/control unit and the register file, and is the parametrised, sequenced successor of the team's 4-to-16 one-hot enable decoder.

---
 rtl/reg_list_sequencer.sv | 118 +++++++++++
 tb/tb_reg_list_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_list_sequencer.sv
// Purpose: walks the set bits of a captured register list, one per enabled cycle, with a one-hot register-file enable.
// Latency: first step 1 cycle after the accepted start; done pulses the cycle after the last step.
// Backpressure: enable=0 stalls the walk with all registered outputs held and e forced to zero.
module reg_list_sequencer #(
    parameter int NREG    = 16,
    parameter int IDX_W   = $clog2(NREG),
    parameter bit DESCEND = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [NREG-1:0]  list,
    input  logic             enable,
    output logic [NREG-1:0]  e,
    output logic [IDX_W-1:0] idx,
    output logic             valid,
    output logic             first,
    output logic             last,
    output logic             busy,
    output logic             done,
    output logic [IDX_W:0]   count
);

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic            state;
    logic [NREG-1:0] pend;

    logic [NREG-1:0]  src;
    logic [IDX_W-1:0] sel;
    logic [NREG-1:0]  rem;
    logic [IDX_W:0]   src_cnt;

    // In IDLE the incoming list is encoded directly; in RUN the pending bits are.
    assign src = (state == IDLE) ? list : pend;

    always_comb begin
        sel = '0;
        if (DESCEND) begin
            for (int i = 0; i < NREG; i++)
                if (src[i]) sel = IDX_W'(i);
        end else begin
            for (int i = NREG - 1; i >= 0; i--)
                if (src[i]) sel = IDX_W'(i);
        end
    end

    always_comb begin
        rem      = src;
        rem[sel] = 1'b0;
    end

    always_comb begin
        src_cnt = '0;
        for (int i = 0; i < NREG; i++)
            src_cnt = src_cnt + (IDX_W+1)'(src[i]);
    end

    // Index 0 maps to the MSB of e.
    always_comb begin
        e = '0;
        for (int i = 0; i < NREG; i++)
            e[NREG-1-i] = valid && enable && (idx == IDX_W'(i));
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            pend  <= '0;
            idx   <= '0;
            valid <= 1'b0;
            first <= 1'b0;
            last  <= 1'b0;
            done  <= 1'b0;
            count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count <= src_cnt;
                        if (list != '0) begin
                            pend  <= rem;
                            idx   <= sel;
                            valid <= 1'b1;
                            first <= 1'b1;
                            last  <= (src_cnt == (IDX_W+1)'(1));
                            state <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (enable) begin
                        if (last) begin
                            valid <= 1'b0;
                            first <= 1'b0;
                            last  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            idx   <= sel;
                            pend  <= rem;
                            first <= 1'b0;
                            last  <= (src_cnt == (IDX_W+1)'(1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Directed bench for reg_list_sequencer: ascending and descending instances share one stimulus stream.
module tb_reg_list_sequencer;

    localparam int NREG  = 16;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [NREG-1:0]  list;
    logic             enable;

    logic [NREG-1:0]  a_e,     d_e;
    logic [IDX_W-1:0] a_idx,   d_idx;
    logic             a_valid, d_valid;
    logic             a_first, d_first;
    logic             a_last,  d_last;
    logic             a_busy,  d_busy;
    logic             a_done,  d_done;
    logic [IDX_W:0]   a_count, d_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    reg_list_sequencer #(.NREG(NREG), .DESCEND(1'b0)) u_asc (
        .clk(clk), .reset_n(reset_n), .start(start), .list(list), .enable(enable),
        .e(a_e), .idx(a_idx), .valid(a_valid), .first(a_first), .last(a_last),
        .busy(a_busy), .done(a_done), .count(a_count)
    );

    reg_list_sequencer #(.NREG(NREG), .DESCEND(1'b1)) u_desc (
        .clk(clk), .reset_n(reset_n), .start(start), .list(list), .enable(enable),
        .e(d_e), .idx(d_idx), .valid(d_valid), .first(d_first), .last(d_last),
        .busy(d_busy), .done(d_done), .count(d_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        list    = '0;
        enable  = 1'b1;
        #1;
        chk("rst_e",     a_e,     16'h0000);
        chk("rst_idx",   a_idx,   0);
        chk("rst_valid", a_valid, 0);
        chk("rst_first", a_first, 0);
        chk("rst_last",  a_last,  0);
        chk("rst_busy",  a_busy,  0);
        chk("rst_done",  a_done,  0);
        chk("rst_count", a_count, 0);
        #7 reset_n = 1'b1;
        tick();

        // 8421 walk, both orders
        start = 1'b1; list = 16'h8421;
        tick();
        start = 1'b0; list = 16'h0000;
        #1;
        chk("s1_idx",   a_idx,   0);
        chk("s1_e",     a_e,     16'h8000);
        chk("s1_first", a_first, 1);
        chk("s1_last",  a_last,  0);
        chk("s1_valid", a_valid, 1);
        chk("s1_busy",  a_busy,  1);
        chk("s1_count", a_count, 4);
        chk("d1_idx",   d_idx,   15);
        chk("d1_e",     d_e,     16'h0001);
        tick();
        chk("s2_idx",   a_idx,   5);
        chk("s2_e",     a_e,     16'h0400);
        chk("s2_first", a_first, 0);
        chk("s2_last",  a_last,  0);
        chk("d2_idx",   d_idx,   10);
        tick();
        chk("s3_idx",   a_idx,   10);
        chk("s3_e",     a_e,     16'h0020);
        chk("d3_idx",   d_idx,   5);
        tick();
        chk("s4_idx",   a_idx,   15);
        chk("s4_e",     a_e,     16'h0001);
        chk("s4_last",  a_last,  1);
        chk("d4_idx",   d_idx,   0);
        chk("d4_e",     d_e,     16'h8000);
        chk("d4_last",  d_last,  1);
        tick();
        chk("end_done",  a_done,  1);
        chk("end_busy",  a_busy,  0);
        chk("end_valid", a_valid, 0);
        chk("end_count", a_count, 4);
        chk("dend_done", d_done,  1);

        // start during the done cycle, single-bit list
        start = 1'b1; list = 16'h0001;
        tick();
        start = 1'b0; list = 16'h0000;
        #1;
        chk("one_valid", a_valid, 1);
        chk("one_first", a_first, 1);
        chk("one_last",  a_last,  1);
        chk("one_idx",   a_idx,   0);
        chk("one_e",     a_e,     16'h8000);
        chk("one_count", a_count, 1);
        chk("one_done",  a_done,  0);
        chk("done_one",  d_idx,   0);
        tick();
        chk("one_end_done", a_done, 1);
        chk("one_end_busy", a_busy, 0);
        tick();
        chk("one_done_pulse", a_done, 0);

        // empty list
        start = 1'b1; list = 16'h0000;
        tick();
        start = 1'b0;
        #1;
        chk("empty_valid", a_valid, 0);
        chk("empty_busy",  a_busy,  0);
        chk("empty_done",  a_done,  1);
        chk("empty_count", a_count, 0);
        chk("empty_e",     a_e,     16'h0000);
        tick();
        chk("empty_done_pulse", a_done, 0);
        chk("empty_busy2",      a_busy, 0);

        // full list with stalls at step 4 and at the last step; start during run ignored
        start = 1'b1; list = 16'hFFFF;
        tick();
        start = 1'b1; list = 16'h0003;
        for (int k = 0; k < 16; k++) begin
            if (k == 2) begin
                start = 1'b0; list = 16'h0000;
            end
            if (k == 3 || k == 15) begin
                repeat (3) begin
                    enable = 1'b0;
                    #1;
                    chk("stall_e",     a_e,     16'h0000);
                    chk("stall_idx",   a_idx,   k);
                    chk("stall_valid", a_valid, 1);
                    chk("stall_didx",  d_idx,   15 - k);
                    tick();
                end
            end
            enable = 1'b1;
            #1;
            chk("full_idx",   a_idx,   k);
            chk("full_e",     a_e,     16'h8000 >> k);
            chk("full_last",  a_last,  (k == 15));
            chk("full_first", a_first, (k == 0));
            chk("full_didx",  d_idx,   15 - k);
            chk("full_done",  a_done,  0);
            tick();
        end
        chk("full_end_done",  a_done,  1);
        chk("full_end_busy",  a_busy,  0);
        chk("full_end_valid", a_valid, 0);
        chk("full_count",     a_count, 16);
        tick();

        // asynchronous reset mid-sequence
        start = 1'b1; list = 16'h00F0;
        tick();
        start = 1'b0; list = 16'h0000;
        tick();
        #1;
        chk("pre_rst_idx", a_idx, 5);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_valid", a_valid, 0);
        chk("arst_idx",   a_idx,   0);
        chk("arst_busy",  a_busy,  0);
        chk("arst_count", a_count, 0);
        chk("arst_e",     a_e,     16'h0000);
        chk("arst_first", a_first, 0);
        chk("arst_last",  a_last,  0);
        chk("arst_done",  a_done,  0);
        #1 reset_n = 1'b1;
        tick();
        chk("post_rst_valid", a_valid, 0);
        chk("post_rst_busy",  a_busy,  0);
        start = 1'b1; list = 16'h0300;
        tick();
        start = 1'b0; list = 16'h0000;
        #1;
        chk("fresh1_idx",   a_idx,   8);
        chk("fresh1_first", a_first, 1);
        chk("fresh1_count", a_count, 2);
        chk("fresh1_e",     a_e,     16'h0080);
        tick();
        chk("fresh2_idx",  a_idx,  9);
        chk("fresh2_last", a_last, 1);
        tick();
        chk("fresh_done",  a_done, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
